// File: rtl/d1_8_pkg.sv
// Shared constants and types for the 1-to-8 registered word distributor.
package d1_8_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NCH   = 8;
    localparam int unsigned SELW  = 3;
    localparam int unsigned CNTW  = 16;

    typedef logic [NCH-1:0]            vec_t;
    typedef logic [NCH-1:0][WIDTH-1:0] data_arr_t;

endpackage

// File: rtl/d1_8_slot.sv
// Single-entry holding register with valid flag; load sets valid, ack clears it.
module d1_8_slot
    import d1_8_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             ack,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             v
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             v_q, v_d;

    // Data holds its last value after a drain; only a load replaces it.
    always_comb begin
        q_d = q_q;
        v_d = v_q;
        if (ack) begin
            v_d = 1'b0;
        end
        if (load) begin
            q_d = d;
            v_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
            v_q <= 1'b0;
        end else begin
            q_q <= q_d;
            v_q <= v_d;
        end
    end

    assign q = q_q;
    assign v = v_q;

endmodule

// File: rtl/d1_8e16b_reg.sv
// Registered 1-to-8 demultiplexer for 16-bit words with per-channel valid/ack,
// accepted-word counter and sticky upstream protocol-error detection.
module d1_8e16b_reg
    import d1_8_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] I,
    input  logic             E,
    input  logic [SELW-1:0]  S,
    output logic             RDY,
    output logic [WIDTH-1:0] O0D,
    output logic [WIDTH-1:0] O1D,
    output logic [WIDTH-1:0] O2D,
    output logic [WIDTH-1:0] O3D,
    output logic [WIDTH-1:0] O4D,
    output logic [WIDTH-1:0] O5D,
    output logic [WIDTH-1:0] O6D,
    output logic [WIDTH-1:0] O7D,
    output logic [NCH-1:0]   OV,
    input  logic [NCH-1:0]   OA,
    output logic [CNTW-1:0]  ACC_CNT,
    output logic             ERR
);

    data_arr_t        data;
    vec_t             valid;
    vec_t             load;
    logic             accept;

    logic [CNTW-1:0]  acc_cnt_q, acc_cnt_d;
    logic             err_q, err_d;
    logic             stall_q, stall_d;
    logic [WIDTH-1:0] stall_i_q, stall_i_d;
    logic [SELW-1:0]  stall_s_q, stall_s_d;

    assign RDY    = ~valid[S];
    assign accept = E & RDY;

    always_comb begin
        load    = '0;
        load[S] = accept;
    end

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        d1_8_slot u_slot (
            .clk  (CLK),
            .rst  (RST),
            .load (load[k]),
            .ack  (OA[k]),
            .d    (I),
            .q    (data[k]),
            .v    (valid[k])
        );
    end

    // A registered stall must be followed by the same word, still offered.
    always_comb begin
        acc_cnt_d = acc_cnt_q;
        err_d     = err_q;
        stall_d   = E & ~RDY;
        stall_i_d = I;
        stall_s_d = S;
        if (accept) begin
            acc_cnt_d = acc_cnt_q + CNTW'(1);
        end
        if (stall_q && (!E || (I != stall_i_q) || (S != stall_s_q))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_cnt_q <= '0;
            err_q     <= 1'b0;
            stall_q   <= 1'b0;
            stall_i_q <= '0;
            stall_s_q <= '0;
        end else begin
            acc_cnt_q <= acc_cnt_d;
            err_q     <= err_d;
            stall_q   <= stall_d;
            stall_i_q <= stall_i_d;
            stall_s_q <= stall_s_d;
        end
    end

    assign OV      = valid;
    assign ACC_CNT = acc_cnt_q;
    assign ERR     = err_q;
    assign O0D     = data[0];
    assign O1D     = data[1];
    assign O2D     = data[2];
    assign O3D     = data[3];
    assign O4D     = data[4];
    assign O5D     = data[5];
    assign O6D     = data[6];
    assign O7D     = data[7];

endmodule
